bullet_wave_scheduler: RTL and testbench
========================================

// Module: bullet_wave_scheduler
// PURPOSE
//  Sequences the bullet table through battle waves: run/reload control, movement step
//  strobes, a per-tick collision scan over all slots, kill pulses and player HP.
//  Sits between the battle top level and the bullet table / collision checker. Drives the
//  table's run, step, index and kill inputs; receives the per-slot hit result back.
// PARAMETERS
//  NUM_BULLETS  3       bullet slots scanned per tick (1..8)
//  IDX_W        3       slot index width
//  TICK_DIV     833333  clk cycles per movement tick; must be >= NUM_BULLETS+4
//  CNT_W        20      tick divider width
//  WAVE_TICKS   240     movement ticks per wave
//  NUM_WAVES    4       waves per battle (1..4)
//  HP_INIT      20      player HP loaded on start
//  INVULN_TICKS 30      ticks of hit immunity (SCHED_INVULN_EN only)
// PORTS
//  clk          in   1      system clock
//  rst_n        in   1      async active-low reset
//  start        in   1      1-cycle pulse: begin battle; ignored unless IDLE/DONE/OVER
//  abort        in   1      level; forces IDLE next cycle; priority over everything
//  hit          in   1      collision result for scan_idx presented the previous cycle
//  run          out  1      1 = table moves; 0 = table reloads initial positions
//  step         out  1      1-cycle pulse per movement tick
//  scan_idx     out  IDX_W  slot under collision test
//  scan_valid   out  1      scan_idx is meaningful this cycle
//  kill         out  1      1-cycle pulse: clear render bit of kill_idx
//  kill_idx     out  IDX_W  slot to clear
//  wave         out  2      current wave number, 0-based
//  hp           out  8      player HP, saturates at 0
//  battle_done  out  1      level: all waves survived (DONE)
//  game_over    out  1      level: hp reached 0 (OVER)
// BEHAVIOUR
//  Reset: state=IDLE; run=0, step=0, scan_valid=0, kill=0, scan_idx=0, kill_idx=0,
//   wave=0, hp=HP_INIT, battle_done=0, game_over=0, divider=0, tick count=0, alive=all 1.
//  States: IDLE -> LOAD -> RUN <-> SCAN -> CLEAR -> LOAD | DONE; any -> OVER; any -> IDLE(abort).
//  IDLE: run=0. On start: hp=HP_INIT, wave=0, go LOAD.
//  LOAD: exactly 1 cycle with run=0 (table reloads); alive=all 1, tick count=0, divider=0; go RUN.
//  RUN: run=1; divider counts 0..TICK_DIV-1. At wrap: step=1 for that cycle,
//   tick count+1, go SCAN.
//  SCAN: scan_idx=0..NUM_BULLETS-1, one per cycle, scan_valid=1; hit is sampled one cycle
//   later (1-cycle latency), so SCAN lasts NUM_BULLETS+1 cycles. The divider keeps counting.
//   Hit for slot i with alive[i]=1: kill=1, kill_idx=i on the sampling cycle, alive[i]=0,
//   hp-=1 (saturate at 0). Hits on dead slots are ignored. Hits with scan_valid low
//   one cycle earlier are ignored.
//   After the last sample: if hp==0 go OVER; else if tick count==WAVE_TICKS go CLEAR;
//   else go RUN.
//  CLEAR: 1 cycle, run=0. If wave==NUM_WAVES-1 go DONE; else wave+1 and go LOAD.
//  DONE: battle_done=1, run=0. OVER: game_over=1, run=0. Both hold until start or abort.
//  The game_over check has priority over wave end when both occur on the same tick.
//  abort mid-scan: any pending kill is dropped. Outputs return to reset values next cycle,
//   except hp, which holds.
//  start while busy (LOAD/RUN/SCAN/CLEAR): ignored.
//  start in the same cycle as abort: abort wins.
//  All outputs are registered. Step-to-first-scan_valid latency is 1 cycle.
// CONFIGURATION
//  SCHED_INVULN_EN defined: after any kill, an immunity counter loads INVULN_TICKS and
//   decrements per step. While it is nonzero, hits still pulse kill/alive but do not
//   decrement hp. The counter clears on LOAD.
//  SCHED_INVULN_EN undefined: every accepted hit decrements hp; no counter is built.
// TESTING
//  Test parameters: TICK_DIV=8, WAVE_TICKS=3, NUM_WAVES=2, HP_INIT=2, NUM_BULLETS=3.
//  1. Reset, start, hit=0 -> one run=0 LOAD cycle; step every 8 clk; scan_idx 0,1,2;
//     wave 0->1 after 3 ticks; battle_done=1; hp=2.
//  2. hit=1 while slot 1 is sampled -> kill=1, kill_idx=1 for 1 cycle; hp=1;
//     a second hit on slot 1 in the next tick does nothing.
//  3. Hits on slots 0 and 2 in one scan -> two kill pulses; hp 2->0; game_over=1,
//     not battle_done, even when this is the final tick.
//  4. abort during SCAN -> next cycle run=0, scan_valid=0, kill=0, IDLE. A start in the
//     same cycle is ignored; a later start reloads hp=2.
//  5. SCHED_INVULN_EN, INVULN_TICKS=2: hits on ticks 1 and 2 -> one hp decrement,
//     two kills; a hit on tick 4 decrements hp.
//  6. start pulsed during RUN -> no change to wave, hp or state.

Source files
------------

// File: rtl/bullet_wave_scheduler.sv
// Battle wave sequencer: run/reload control, movement steps, per-tick collision scan, kills, HP.
// Optional hit immunity after a kill is built when SCHED_INVULN_EN is defined.
module bullet_wave_scheduler #(
   parameter int unsigned NUM_BULLETS  = 3,
   parameter int unsigned IDX_W        = 3,
   parameter int unsigned TICK_DIV     = 833333,
   parameter int unsigned CNT_W        = 20,
   parameter int unsigned WAVE_TICKS   = 240,
   parameter int unsigned NUM_WAVES    = 4,
   parameter int unsigned HP_INIT      = 20,
   parameter int unsigned INVULN_TICKS = 30
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             hit,
   output logic             run,
   output logic             step,
   output logic [IDX_W-1:0] scan_idx,
   output logic             scan_valid,
   output logic             kill,
   output logic [IDX_W-1:0] kill_idx,
   output logic [1:0]       wave,
   output logic [7:0]       hp,
   output logic             battle_done,
   output logic             game_over
);

   typedef enum logic [2:0] {
      StIdle, StLoad, StRun, StScan, StClear, StDone, StOver
   } state_e;

   localparam int unsigned TICK_W = $clog2(WAVE_TICKS + 1);
   localparam int unsigned SLOTS  = 2 ** IDX_W;
   localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0]  DIV_STEP  = CNT_W'(TICK_DIV - 2);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_BULLETS - 1);
   localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(WAVE_TICKS);
   localparam logic [1:0]        LAST_WAVE = 2'(NUM_WAVES - 1);

   state_e            state_q;
   logic [CNT_W-1:0]  div_q;
   logic [TICK_W-1:0] tick_q;
   logic [SLOTS-1:0]  alive_q;
   logic              pend_valid_q;
   logic [IDX_W-1:0]  pend_idx_q;
   logic              accept;
   logic              immune;
   logic [7:0]        hp_next;

`ifdef SCHED_INVULN_EN
   localparam int unsigned INV_W = $clog2(INVULN_TICKS + 2);
   logic [INV_W-1:0] inv_q;
   assign immune = (inv_q != '0);
`else
   assign immune = 1'b0;
`endif

   // pend_* is last cycle's scan slot; hit this cycle answers it
   always_comb begin
      accept  = pend_valid_q && hit && alive_q[pend_idx_q];
      hp_next = hp;
      if (accept && !immune && hp != 8'd0) hp_next = hp - 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         run          <= 1'b0;
         step         <= 1'b0;
         scan_idx     <= '0;
         scan_valid   <= 1'b0;
         kill         <= 1'b0;
         kill_idx     <= '0;
         wave         <= 2'd0;
         hp           <= 8'(HP_INIT);
         battle_done  <= 1'b0;
         game_over    <= 1'b0;
         div_q        <= '0;
         tick_q       <= '0;
         alive_q      <= '1;
         pend_valid_q <= 1'b0;
         pend_idx_q   <= '0;
`ifdef SCHED_INVULN_EN
         inv_q        <= '0;
`endif
      end else begin
         kill         <= 1'b0;
         step         <= 1'b0;
         pend_valid_q <= scan_valid;
         pend_idx_q   <= scan_idx;
`ifdef SCHED_INVULN_EN
         if (step && inv_q != '0) inv_q <= inv_q - 1'b1;
`endif
         if (abort) begin
            state_q      <= StIdle;
            run          <= 1'b0;
            scan_idx     <= '0;
            scan_valid   <= 1'b0;
            kill_idx     <= '0;
            wave         <= 2'd0;
            battle_done  <= 1'b0;
            game_over    <= 1'b0;
            div_q        <= '0;
            tick_q       <= '0;
            alive_q      <= '1;
            pend_valid_q <= 1'b0;
`ifdef SCHED_INVULN_EN
            inv_q        <= '0;
`endif
         end else begin
            if (accept) begin
               kill                <= 1'b1;
               kill_idx            <= pend_idx_q;
               alive_q[pend_idx_q] <= 1'b0;
               hp                  <= hp_next;
`ifdef SCHED_INVULN_EN
               inv_q               <= INV_W'(INVULN_TICKS);
`endif
            end
            unique case (state_q)
               StIdle, StDone, StOver: begin
                  if (start) begin
                     hp          <= 8'(HP_INIT);
                     wave        <= 2'd0;
                     battle_done <= 1'b0;
                     game_over   <= 1'b0;
                     state_q     <= StLoad;
                  end
               end
               StLoad: begin
                  alive_q <= '1;
                  tick_q  <= '0;
                  div_q   <= '0;
                  run     <= 1'b1;
                  state_q <= StRun;
`ifdef SCHED_INVULN_EN
                  inv_q   <= '0;
`endif
               end
               StRun: begin
                  div_q <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
                  // Step lands on the wrap cycle so the first scan slot follows it directly
                  if (div_q == DIV_STEP) step <= 1'b1;
                  if (div_q == DIV_LAST) begin
                     tick_q     <= tick_q + 1'b1;
                     scan_valid <= 1'b1;
                     scan_idx   <= '0;
                     state_q    <= StScan;
                  end
               end
               StScan: begin
                  div_q <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
                  if (scan_valid) begin
                     if (scan_idx == LAST_IDX) begin
                        scan_valid <= 1'b0;
                        scan_idx   <= '0;
                     end else begin
                        scan_idx <= scan_idx + 1'b1;
                     end
                  end else if (hp_next == 8'd0) begin
                     run       <= 1'b0;
                     game_over <= 1'b1;
                     state_q   <= StOver;
                  end else if (tick_q == LAST_TICK) begin
                     run     <= 1'b0;
                     state_q <= StClear;
                  end else begin
                     state_q <= StRun;
                  end
               end
               StClear: begin
                  if (wave == LAST_WAVE) begin
                     battle_done <= 1'b1;
                     state_q     <= StDone;
                  end else begin
                     wave    <= wave + 2'd1;
                     state_q <= StLoad;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bullet_wave_scheduler.sv
// Self-checking bench for bullet_wave_scheduler: cycle-exact hand sequences plus a table of
// whole-battle hit patterns with hand-computed outcomes (both immunity builds).
module tb_bullet_wave_scheduler;

   logic       clk = 1'b0;
   logic       rst_n, start, abort, hit;
   logic       run, step, scan_valid, kill, battle_done, game_over;
   logic [2:0] scan_idx, kill_idx;
   logic [1:0] wave;
   logic [7:0] hp;

   always #5 clk = ~clk;

`ifdef SCHED_INVULN_EN
   localparam bit INV = 1'b1;
`else
   localparam bit INV = 1'b0;
`endif

   bullet_wave_scheduler #(
      .NUM_BULLETS(3), .IDX_W(3), .TICK_DIV(8), .CNT_W(4), .WAVE_TICKS(3),
      .NUM_WAVES(2), .HP_INIT(2), .INVULN_TICKS(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .hit(hit),
      .run(run), .step(step), .scan_idx(scan_idx), .scan_valid(scan_valid),
      .kill(kill), .kill_idx(kill_idx), .wave(wave), .hp(hp),
      .battle_done(battle_done), .game_over(game_over)
   );

   typedef struct packed {
      logic [7:0] hp;
      logic       done;
      logic       over;
      logic [7:0] kills;
      logic [1:0] wave;
      logic [7:0] steps;
   } res_t;

   typedef struct packed {
      logic [17:0] hits;  // 3 bits per tick, tick 1 in the LSBs, bit i = slot i
      res_t        dflt;
      res_t        inv;
   } vec_t;

   vec_t       vecs [8];
   int         passed = 0;
   int         total  = 0;
   int         kills, steps;
   logic [7:0] cur_mask;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Collision-checker stand-in: answers last cycle's scan slot from cur_mask
   task automatic cyc();
      logic       sv;
      logic [2:0] si;
      sv = scan_valid;
      si = scan_idx;
      @(posedge clk);
      #1;
      hit = sv && cur_mask[si];
      if (step) steps++;
      if (kill) kills++;
   endtask

   function automatic logic [17:0] h(input logic [2:0] t1, t2, t3, t4, t5, t6);
      return {t6, t5, t4, t3, t2, t1};
   endfunction

   function automatic logic [2:0] tick_mask(input logic [17:0] hv, input int t);
      if (t < 1 || t > 6) return 3'b000;
      return hv[3*(t-1) +: 3];
   endfunction

   function automatic res_t r(input int hp_, done_, over_, kills_, wave_, steps_);
      res_t x;
      x.hp    = 8'(hp_);
      x.done  = (done_ != 0);
      x.over  = (over_ != 0);
      x.kills = 8'(kills_);
      x.wave  = 2'(wave_);
      x.steps = 8'(steps_);
      return x;
   endfunction

   task automatic run_battle(input logic [17:0] hv, output logic finished);
      kills    = 0;
      steps    = 0;
      cur_mask = 8'd0;
      start    = 1'b1;
      cyc();
      start    = 1'b0;
      finished = 1'b0;
      for (int c = 0; c < 300 && !finished; c++) begin
         cur_mask = {5'd0, tick_mask(hv, steps)};
         cyc();
         if (battle_done || game_over) finished = 1'b1;
      end
      cur_mask = 8'd0;
   endtask

   initial begin
      logic finished;
      res_t e;

      //            hits                                    default               immunity
      vecs[0] = '{h(0, 0, 0, 0, 0, 0),           r(2, 1, 0, 0, 1, 6), r(2, 1, 0, 0, 1, 6)};
      vecs[1] = '{h(3'b010, 3'b010, 0, 0, 0, 0), r(1, 1, 0, 1, 1, 6), r(1, 1, 0, 1, 1, 6)};
      vecs[2] = '{h(0, 0, 0, 0, 0, 3'b101),      r(0, 0, 1, 2, 1, 6), r(1, 1, 0, 2, 1, 6)};
      vecs[3] = '{h(3'b001, 0, 0, 3'b001, 0, 0), r(0, 0, 1, 2, 1, 4), r(0, 0, 1, 2, 1, 4)};
      vecs[4] = '{h(0, 3'b100, 0, 0, 3'b010, 0), r(0, 0, 1, 2, 1, 5), r(0, 0, 1, 2, 1, 5)};
      vecs[5] = '{h(0, 0, 3'b001, 0, 0, 0),      r(1, 1, 0, 1, 1, 6), r(1, 1, 0, 1, 1, 6)};
      vecs[6] = '{h(3'b001, 0, 3'b010, 0, 0, 0), r(0, 0, 1, 2, 0, 3), r(0, 0, 1, 2, 0, 3)};
      vecs[7] = '{h(3'b001, 3'b010, 0, 3'b100, 0, 0),
                  r(0, 0, 1, 2, 0, 2), r(0, 0, 1, 3, 1, 4)};

      rst_n    = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      hit      = 1'b0;
      cur_mask = 8'd0;
      kills    = 0;
      steps    = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      chk("rst_run", run, 0);
      chk("rst_step_scan_kill", {step, scan_valid, kill}, 0);
      chk("rst_idx", {scan_idx, kill_idx}, 0);
      chk("rst_hp", hp, 2);
      chk("rst_wave", wave, 0);
      chk("rst_done_over", {battle_done, game_over}, 0);

      // Load cycle, step period, scan order, single kill
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("load_run_low", run, 0);
      cyc();
      chk("run_high", run, 1);
      chk("no_early_step", step, 0);
      repeat (7) cyc();
      chk("step_first", step, 1);
      cur_mask = 8'b010;
      cyc();
      chk("scan0", {scan_valid, scan_idx}, {1'b1, 3'd0});
      cyc();
      chk("scan1", {scan_valid, scan_idx}, {1'b1, 3'd1});
      cyc();
      chk("scan2", {scan_valid, scan_idx}, {1'b1, 3'd2});
      cyc();
      chk("kill_slot1", {kill, kill_idx}, {1'b1, 3'd1});
      chk("hp_after_kill", hp, 1);
      chk("scan_end", scan_valid, 0);
      cyc();
      chk("kill_one_cycle", kill, 0);
      repeat (2) cyc();
      chk("no_step_mid", step, 0);
      cyc();
      chk("step_period", step, 1);

      // Abort with a kill pending, start in the same cycle
      cur_mask = 8'b011;
      kills    = 0;
      cyc();
      cyc();
      abort = 1'b1;
      start = 1'b1;
      cyc();
      abort = 1'b0;
      start = 1'b0;
      chk("abort_outputs", {run, scan_valid, kill}, 0);
      chk("abort_hp_hold", hp, 1);
      cur_mask = 8'd0;
      repeat (3) cyc();
      chk("abort_idle", run, 0);
      chk("abort_drops_kill", kills, 0);
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("restart_hp", hp, 2);

      // Start while running is ignored
      repeat (3) cyc();
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("start_in_run", {run, wave, hp}, {1'b1, 2'd0, 8'd2});
      repeat (4) cyc();
      chk("run_unperturbed", step, 1);
      for (int c = 0; c < 300 && !(battle_done || game_over); c++) cyc();
      chk("clean_done", {battle_done, game_over}, {1'b1, 1'b0});
      chk("clean_wave_hp", {wave, hp}, {2'd1, 8'd2});

      for (int i = 0; i < 8; i++) begin
         e = INV ? vecs[i].inv : vecs[i].dflt;
         run_battle(vecs[i].hits, finished);
         chk($sformatf("v%0d_finished", i), finished, 1);
         chk($sformatf("v%0d_hp", i), hp, e.hp);
         chk($sformatf("v%0d_done", i), battle_done, e.done);
         chk($sformatf("v%0d_over", i), game_over, e.over);
         chk($sformatf("v%0d_kills", i), kills, e.kills);
         chk($sformatf("v%0d_wave", i), wave, e.wave);
         chk($sformatf("v%0d_steps", i), steps, e.steps);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
